// File: rtl/fsm_prog_sequence_counter.sv
// fsm_prog_sequence_counter: steps forward or backward through a run-time writable table of DEPTH codes.
// Build option SEQ_ONESHOT_EN: stop at the end of the sequence and raise done instead of wrapping.
module fsm_prog_sequence_counter #(
    parameter int W     = 3,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          dir,
    input  logic          clr,
    input  logic [AW-1:0] last,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  num,
    output logic [AW-1:0] idx,
    output logic          wrap,
    output logic          done
);

    localparam logic [AW-1:0] MAX_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE     = AW'(1);

    logic [W-1:0]  tbl [DEPTH];
    logic [AW-1:0] idx_q, idx_d, l_eff;
    logic          wrap_q, wrap_d;
    logic          at_end, step, addr_ok;

`ifdef SEQ_ONESHOT_EN
    logic done_q, done_d;
    assign step = en && !done_q;
    assign done = done_q;
`else
    assign step = en;
    assign done = 1'b0;
`endif

    // last can exceed DEPTH-1 when DEPTH is not a power of two; clamp it
    assign l_eff   = (int'(last) > DEPTH - 1) ? MAX_IDX : last;
    assign addr_ok = int'(wr_addr) < DEPTH;
    assign at_end  = dir ? (idx_q == '0) : (idx_q >= l_eff);

    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
`ifdef SEQ_ONESHOT_EN
        done_d = done_q;
`endif
        if (clr) begin
            idx_d = '0;
`ifdef SEQ_ONESHOT_EN
            done_d = 1'b0;
`endif
        end else if (step) begin
            if (at_end) begin
`ifdef SEQ_ONESHOT_EN
                done_d = 1'b1;
`else
                idx_d  = dir ? l_eff : '0;
                wrap_d = 1'b1;
`endif
            end else if (dir && (idx_q > l_eff)) begin
                idx_d = l_eff;
            end else if (dir) begin
                idx_d = idx_q - ONE;
            end else begin
                idx_d = idx_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
`ifdef SEQ_ONESHOT_EN
            done_q <= 1'b0;
`endif
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
`ifdef SEQ_ONESHOT_EN
            done_q <= done_d;
`endif
        end
    end

    // Table resets to the identity so the default order is a plain up-count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= W'(i);
            end
        end else if (wr_en && addr_ok) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign num  = tbl[idx_q];

endmodule

// File: tb/tb_fsm_prog_sequence_counter.sv
// Self-checking bench for fsm_prog_sequence_counter: vector table, corner sequences, random vs reference model.
// Also builds with SEQ_ONESHOT_EN defined to cover the one-shot variant.
module tb_fsm_prog_sequence_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0, dir = 1'b0, clr = 1'b0, wr_en = 1'b0;
    logic [2:0] last = 3'd7, wr_addr = 3'd0, wr_data = 3'd0;
    logic [2:0] num, idx;
    logic       wrap, done;

    int errors = 0;
    int checks = 0;

    fsm_prog_sequence_counter #(.W(3), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .clr(clr), .last(last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num(num), .idx(idx), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: sequence position, last-step flags and table contents
    int   m_idx;
    bit   m_wrap, m_done;
    int   m_tbl [8];

    task automatic model_reset();
        m_idx = 0; m_wrap = 0; m_done = 0;
        for (int i = 0; i < 8; i++) m_tbl[i] = i;
    endtask

    task automatic model_edge(input bit e, input bit d, input bit c, input int lst,
                              input bit we, input int wa, input int wd);
        int  len_last;
        int  nxt;
        bit  w;
        bit  wraps;
        len_last = (lst > 7) ? 7 : lst;
        nxt = m_idx;
        w = 0;
        if (c) begin
            nxt = 0;
            m_done = 0;
        end else if (e && !m_done) begin
            wraps = d ? (m_idx == 0) : (m_idx >= len_last);
            if (wraps) begin
`ifdef SEQ_ONESHOT_EN
                m_done = 1;
`else
                nxt = d ? len_last : 0;
                w = 1;
`endif
            end else if (d && m_idx > len_last) begin
                nxt = len_last;
            end else begin
                nxt = d ? m_idx - 1 : m_idx + 1;
            end
        end
        if (we && wa < 8) m_tbl[wa] = wd;
        m_idx = nxt;
        m_wrap = w;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_idx"}, int'(idx), m_idx);
        chk({tag, "_num"}, int'(num), m_tbl[m_idx]);
        chk({tag, "_wrap"}, int'(wrap), int'(m_wrap));
        chk({tag, "_done"}, int'(done), int'(m_done));
    endtask

    // Drive one cycle's inputs at the negedge, clock, update the model, sample at next negedge
    task automatic step(input bit e, input bit d, input bit c, input logic [2:0] lst,
                        input bit we, input logic [2:0] wa, input logic [2:0] wd);
        en = e; dir = d; clr = c; last = lst; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        model_edge(e, d, c, int'(lst), we, int'(wa), int'(wd));
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, last, 0, 0, 0);
    endtask

    typedef struct {
        bit         en, dir, clr;
        logic [2:0] last;
        bit         wr_en;
        logic [2:0] wr_addr, wr_data;
        int         e_idx, e_num;
        bit         e_wrap, e_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_idx", int'(idx), 0);
        chk("rst_num", int'(num), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_done", int'(done), 0);

`ifndef SEQ_ONESHOT_EN
        // Plain up-count through the identity table, then wrap
        for (int i = 1; i <= 7; i++)
            vecs.push_back('{1, 0, 0, 3'd7, 0, 3'd0, 3'd0, i, i, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd7, 0, 3'd0, 3'd0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 3'd7, 0, 3'd0, 3'd0, 0, 0, 0, 0});
        // Program {1,6,3,5,4,2}; entry 0 is at idx so num follows immediately
        vecs.push_back('{0, 0, 0, 3'd5, 1, 3'd0, 3'd1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 3'd5, 1, 3'd1, 3'd6, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 3'd5, 1, 3'd2, 3'd3, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 3'd5, 1, 3'd3, 3'd5, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 3'd5, 1, 3'd4, 3'd4, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 3'd5, 1, 3'd5, 3'd2, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd5, 0, 3'd0, 3'd0, 1, 6, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd5, 0, 3'd0, 3'd0, 2, 3, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd5, 0, 3'd0, 3'd0, 3, 5, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd5, 0, 3'd0, 3'd0, 4, 4, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd5, 0, 3'd0, 3'd0, 5, 2, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd5, 0, 3'd0, 3'd0, 0, 1, 1, 0});
        vecs.push_back('{1, 1, 0, 3'd5, 0, 3'd0, 3'd0, 5, 2, 1, 0});
        vecs.push_back('{1, 1, 0, 3'd5, 0, 3'd0, 3'd0, 4, 4, 0, 0});
`else
        // One-shot: last=3, en held -> 1,2,3 then hold at 3 with done, never wrap
        vecs.push_back('{1, 0, 0, 3'd3, 0, 3'd0, 3'd0, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd3, 0, 3'd0, 3'd0, 2, 2, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd3, 0, 3'd0, 3'd0, 3, 3, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd3, 0, 3'd0, 3'd0, 3, 3, 0, 1});
        vecs.push_back('{1, 0, 0, 3'd3, 0, 3'd0, 3'd0, 3, 3, 0, 1});
        vecs.push_back('{1, 1, 0, 3'd3, 0, 3'd0, 3'd0, 3, 3, 0, 1});
        vecs.push_back('{1, 0, 1, 3'd3, 0, 3'd0, 3'd0, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 3'd3, 0, 3'd0, 3'd0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 3'd3, 0, 3'd0, 3'd0, 0, 0, 0, 0});
`endif
        foreach (vecs[k]) begin
            step(vecs[k].en, vecs[k].dir, vecs[k].clr, vecs[k].last,
                 vecs[k].wr_en, vecs[k].wr_addr, vecs[k].wr_data);
            chk($sformatf("vec%0d_idx", k), int'(idx), vecs[k].e_idx);
            chk($sformatf("vec%0d_num", k), int'(num), vecs[k].e_num);
            chk($sformatf("vec%0d_wrap", k), int'(wrap), int'(vecs[k].e_wrap));
            chk($sformatf("vec%0d_done", k), int'(done), int'(vecs[k].e_done));
        end

        // Shrink last below idx: forward wraps (or stops in one-shot), backward lands on last
        step(0, 0, 1, 3'd7, 0, 0, 0);
        repeat (4) step(1, 0, 0, 3'd7, 0, 0, 0);
        chk("shrink_pre_idx", int'(idx), 4);
        step(1, 0, 0, 3'd2, 0, 0, 0);
`ifdef SEQ_ONESHOT_EN
        chk("shrink_fwd_idx", int'(idx), 4);
        chk("shrink_fwd_done", int'(done), 1);
`else
        chk("shrink_fwd_idx", int'(idx), 0);
        chk("shrink_fwd_wrap", int'(wrap), 1);
`endif
        step(0, 0, 1, 3'd7, 0, 0, 0);
        repeat (4) step(1, 0, 0, 3'd7, 0, 0, 0);
        step(1, 1, 0, 3'd2, 0, 0, 0);
        chk("shrink_bwd_idx", int'(idx), 2);
        chk("shrink_bwd_wrap", int'(wrap), 0);

        // clr wins over en
        step(0, 0, 1, 3'd7, 0, 0, 0);
        repeat (3) step(1, 0, 0, 3'd7, 0, 0, 0);
        chk("clr_pre_idx", int'(idx), 3);
        step(1, 0, 1, 3'd7, 0, 0, 0);
        chk("clr_en_idx", int'(idx), 0);
        chk("clr_en_wrap", int'(wrap), 0);

        // Write at the current idx with no step
        repeat (2) step(1, 0, 0, 3'd7, 0, 0, 0);
        step(0, 0, 0, 3'd7, 1, 3'd2, 3'd5);
        chk("wr_cur_idx", int'(idx), 2);
        chk("wr_cur_num", int'(num), 5);

        // Async reset mid-sequence restores idx and the identity table without a clock
        step(0, 0, 0, 3'd7, 1, 3'd0, 3'd6);
        step(1, 0, 0, 3'd7, 1, 3'd1, 3'd7);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_idx", int'(idx), 0);
        chk("arst_num", int'(num), 0);
        chk("arst_wrap", int'(wrap), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 0, 0, 3'd7, 0, 0, 0);
        chk("arst_ident_num", int'(num), 1);
        chk_model("arst");

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            chk_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
